// File: rtl/uart_rx.sv
// UART receiver: recovers 8N1 frames from an asynchronous serial line and strobes out good bytes.
// Optional 8E1/8O1 support is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int PARITY_ODD   = 0
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Parity_Err
);

  localparam logic [7:0] LAST_CNT     = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF_CNT     = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic       PARITY_SENSE = (PARITY_ODD != 0);

`ifdef UART_RX_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    CLEANUP   = 3'd5,
    WAIT_IDLE = 3'd6
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bitIdx_q, bitIdx_d;
  logic [7:0] data_q, data_d;
  logic [7:0] byte_q, byte_d;
  logic       dv_q, dv_d;
  logic       active_q, active_d;
  logic       frameErr_q, frameErr_d;
  logic       parityErr_q, parityErr_d;
  logic       parityBad_q, parityBad_d;
  logic       rxMeta_q, rxSync_q;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= i_Rx_Serial;
      rxSync_q <= rxMeta_q;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      bitIdx_q    <= 3'd0;
      data_q      <= 8'h00;
      byte_q      <= 8'h00;
      dv_q        <= 1'b0;
      active_q    <= 1'b0;
      frameErr_q  <= 1'b0;
      parityErr_q <= 1'b0;
      parityBad_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitIdx_q    <= bitIdx_d;
      data_q      <= data_d;
      byte_q      <= byte_d;
      dv_q        <= dv_d;
      active_q    <= active_d;
      frameErr_q  <= frameErr_d;
      parityErr_q <= parityErr_d;
      parityBad_q <= parityBad_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitIdx_d    = bitIdx_q;
    data_d      = data_q;
    byte_d      = byte_q;
    dv_d        = 1'b0;
    active_d    = active_q;
    frameErr_d  = 1'b0;
    parityErr_d = 1'b0;
    parityBad_d = parityBad_q;

    case (state_q)
      IDLE: begin
        cnt_d       = 8'd0;
        bitIdx_d    = 3'd0;
        parityBad_d = 1'b0;
        active_d    = 1'b0;
        if (!rxSync_q) begin
          state_d  = START;
          active_d = 1'b1;
        end
      end

      // Re-check the line half a bit in; a high here was only a glitch.
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = 8'd0;
          if (!rxSync_q) begin
            state_d  = DATA;
            bitIdx_d = 3'd0;
          end else begin
            state_d  = IDLE;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d            = 8'd0;
          data_d[bitIdx_q] = rxSync_q;
          bitIdx_d         = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      PARITY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d       = 8'd0;
          parityBad_d = (rxSync_q != ((^data_q) ^ PARITY_SENSE));
          state_d     = STOP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      // Framing error outranks parity error when both are present.
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d    = 8'd0;
          active_d = 1'b0;
          if (!rxSync_q) begin
            frameErr_d = 1'b1;
            state_d    = WAIT_IDLE;
          end else if (parityBad_q) begin
            parityErr_d = 1'b1;
            state_d     = CLEANUP;
          end else begin
            byte_d  = data_q;
            dv_d    = 1'b1;
            state_d = CLEANUP;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      CLEANUP: begin
        state_d = IDLE;
      end

      // A held-low (break) line must not be decoded as a stream of frames.
      WAIT_IDLE: begin
        if (rxSync_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  assign o_Rx_DV         = dv_q;
  assign o_Rx_Byte       = byte_q;
  assign o_Rx_Active     = active_q;
  assign o_Rx_Frame_Err  = frameErr_q;
  assign o_Rx_Parity_Err = parityErr_q & PARITY_EN;

endmodule
